sd_audio_i2s_tx: RTL and testbench
==================================

// Module: sd_audio_i2s_tx
// PURPOSE
//  Downstream stage of the SD-card audio reader. Pulls the raw PCM byte stream from the
//  SD read FIFO and packs it into 16-bit little-endian stereo samples (L lo, L hi, R lo, R hi).
//  Serializes the samples onto an I2S output (BCLK/LRCK/SDATA) for the external audio codec.
//  Runs in the audio clock domain. Inserts silence on underrun.
// PARAMETERS
//  BCLK_DIV  8   BCLK half-period in clk cycles; legal range >= 2
// PORTS
//  clk            in   1  audio clock, the same clock as the FIFO read side
//  rst_n          in   1  asynchronous active-low reset
//  enable         in   1  run/stop; when low, all state is cleared and outputs are idle
//  byte_valid     in   1  FIFO byte available
//  byte_data      in   8  FIFO read byte
//  byte_ready     out  1  byte consumed this cycle when byte_valid & byte_ready
//  i2s_bclk       out  1  I2S bit clock
//  i2s_lrck       out  1  I2S word select; 0 = left, 1 = right
//  i2s_sdata      out  1  I2S serial data, MSB first, changes on BCLK falling edge
//  sample_strobe  out  1  one-cycle pulse at each frame load
//  underrun       out  1  one-cycle pulse when a frame load finds no complete sample
// BEHAVIOUR
//  Reset: byte_ready=0, i2s_bclk=0, i2s_lrck=0, i2s_sdata=0, sample_strobe=0, underrun=0;
//    div_cnt=0, bit_cnt=63, assembler state=S_L0, buffer and shadow registers=0.
//  Assembler FSM states: S_L0 -> S_L1 -> S_R0 -> S_R1 -> S_FULL.
//    byte_ready = enable & (state != S_FULL); it is combinational from registered state.
//    Each accepted byte advances one state. S_L0 and S_R0 write the low byte; S_L1 and S_R1 write the high byte.
//    S_FULL holds {L,R} until a frame load, then goes to S_L0. A load and a byte accept never coincide.
//  Divider: div_cnt counts 0..BCLK_DIV-1. At terminal count it wraps and i2s_bclk toggles.
//    A 1->0 toggle is a falling event.
//  Falling event: bit_cnt <= bit_cnt+1 mod 64 (6-bit wrap).
//    If the new bit_cnt is 0 (frame load):
//      - State S_FULL: shadow {L,R} <= buffer, state <= S_L0.
//      - Any other state: shadow <= 0, underrun pulses, and the partial assembly is kept.
//      - sample_strobe pulses in the same cycle.
//  Outputs are registered on the same cycle as the event, from the new bit_cnt k:
//    i2s_lrck  = (k >= 31 && k <= 62), so word select changes one BCLK before each MSB.
//    i2s_sdata = L[15-k] for k=0..15; R[15-(k-32)] for k=32..47; 0 otherwise (zero padding).
//  Frame = 64 BCLK = 128*BCLK_DIV clk cycles; exactly one sample (4 bytes) is consumed per frame.
//  enable=0: synchronous clear of div_cnt, bit_cnt (to 63), FSM (partial bytes discarded) and outputs.
//    Shadow and buffer are cleared. Re-enable starts a fresh frame with k=0 on the first falling event.
//  Reset mid-operation: immediate return to reset values with no partial-frame output.
// CONFIGURATION
//  AUDIO_VOLUME_EN defined: adds input port vol_shift[3:0]. At each frame load, L and R are each
//    arithmetic right shifted by vol_shift (sign-extended). vol_shift >= 15 yields 0x0000 or 0xFFFF.
//  AUDIO_VOLUME_EN undefined: vol_shift is absent and samples pass through unmodified.
// TESTING
//  1. BCLK_DIV=2, enable=1, feed 34,12,78,56 -> bits k0..15 = 0x1234, k32..47 = 0x5678.
//     BCLK period 4 clk; LRCK period 256 clk; one sample_strobe per frame.
//  2. byte_valid=0 for 3 frames -> underrun and sample_strobe pulse at every load; i2s_sdata constantly 0.
//  3. byte_valid held 1 with an incrementing byte pattern -> byte_ready drops after the 4th byte until the
//     next load; exactly 4 bytes are accepted per 64 BCLK, with no loss or duplication.
//  4. Accept 2 bytes, then enable=0 for 5 cycles, then re-enable -> outputs 0 during the stop.
//     The next byte lands in L low; the first frame after re-enable underruns.
//  5. Assert rst_n=0 at k=20 -> all outputs 0 and bit_cnt=63 asynchronously; after release,
//     the first falling event gives k=0 with an underrun pulse.
//  6. AUDIO_VOLUME_EN, vol_shift=1, L=0x8000, R=0x4000 -> serialized L=0xC000, R=0x2000.
//     With vol_shift=15, L=0xFFFF and R=0x0000.

Source files
------------

// File: rtl/sd_audio_i2s_tx.sv
// SD-card audio back end: packs FIFO bytes into 16-bit stereo samples and serializes them as I2S.
// Optional AUDIO_VOLUME_EN adds vol_shift[3:0], an arithmetic attenuation applied at each frame load.
module sd_audio_i2s_tx #(
  parameter int BCLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
`ifdef AUDIO_VOLUME_EN
  input  logic [3:0] vol_shift,
`endif
  output logic       byte_ready,
  output logic       i2s_bclk,
  output logic       i2s_lrck,
  output logic       i2s_sdata,
  output logic       sample_strobe,
  output logic       underrun
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  localparam logic [2:0] S_L0   = 3'd0;
  localparam logic [2:0] S_L1   = 3'd1;
  localparam logic [2:0] S_R0   = 3'd2;
  localparam logic [2:0] S_R1   = 3'd3;
  localparam logic [2:0] S_FULL = 3'd4;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       state_q, state_d;
  logic [15:0]      buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [15:0]      shd_l_q, shd_l_d, shd_r_q, shd_r_d;
  logic             lrck_q, lrck_d;
  logic             sdata_q, sdata_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;

  logic             div_tc;
  logic             fall_evt;
  logic [5:0]       bit_nxt;
  logic             accept;
  logic [15:0]      scaled_l, scaled_r;

  assign div_tc     = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
  assign fall_evt   = div_tc & bclk_q;
  assign bit_nxt    = bit_cnt_q + 6'd1;
  assign byte_ready = enable & (state_q != S_FULL);
  assign accept     = byte_valid & byte_ready;

`ifdef AUDIO_VOLUME_EN
  assign scaled_l = 16'($signed(buf_l_q) >>> vol_shift);
  assign scaled_r = 16'($signed(buf_r_q) >>> vol_shift);
`else
  assign scaled_l = buf_l_q;
  assign scaled_r = buf_r_q;
`endif

  always_comb begin
    // NOTE: every next-state signal takes its current value first so no path leaves it unassigned (no latches).
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    state_d    = state_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    shd_l_d    = shd_l_q;
    shd_r_d    = shd_r_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;

    if (!enable) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
      bit_cnt_d = 6'd63;
      state_d   = S_L0;
      buf_l_d   = '0;
      buf_r_d   = '0;
      shd_l_d   = '0;
      shd_r_d   = '0;
      lrck_d    = 1'b0;
      sdata_d   = 1'b0;
    end else begin
      div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
      if (div_tc) bclk_d = ~bclk_q;

      if (accept) begin
        case (state_q)
          S_L0:    begin buf_l_d[7:0]  = byte_data; state_d = S_L1;   end
          S_L1:    begin buf_l_d[15:8] = byte_data; state_d = S_R0;   end
          S_R0:    begin buf_r_d[7:0]  = byte_data; state_d = S_R1;   end
          S_R1:    begin buf_r_d[15:8] = byte_data; state_d = S_FULL; end
          default: state_d = state_q;
        endcase
      end

      if (fall_evt) begin
        bit_cnt_d = bit_nxt;
        if (bit_nxt == 6'd0) begin
          strobe_d = 1'b1;
          // A load in FULL never meets an accept, so the state rewrite cannot collide.
          if (state_q == S_FULL) begin
            shd_l_d = scaled_l;
            shd_r_d = scaled_r;
            state_d = S_L0;
          end else begin
            shd_l_d    = '0;
            shd_r_d    = '0;
            underrun_d = 1'b1;
          end
        end
        lrck_d = (bit_nxt >= 6'd31) && (bit_nxt <= 6'd62);
        // 15-k within each 16-bit slot is the bitwise inverse of k[3:0].
        case (bit_nxt[5:4])
          2'b00:   sdata_d = shd_l_d[~bit_nxt[3:0]];
          2'b10:   sdata_d = shd_r_d[~bit_nxt[3:0]];
          default: sdata_d = 1'b0;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= 6'd63;
      state_q    <= S_L0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      shd_l_q    <= '0;
      shd_r_q    <= '0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      state_q    <= state_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      shd_l_q    <= shd_l_d;
      shd_r_q    <= shd_r_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign i2s_bclk      = bclk_q;
  assign i2s_lrck      = lrck_q;
  assign i2s_sdata     = sdata_q;
  assign sample_strobe = strobe_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_sd_audio_i2s_tx.sv
// Directed bench for sd_audio_i2s_tx with BCLK_DIV=2 (frame = 256 clk, falling event every 4 clk).
// Byte source: src[n] is presented while fewer than feed_limit bytes have been accepted.
module tb_sd_audio_i2s_tx;

  localparam int BCLK_DIV = 2;
  localparam int FRAME_CYC = 128 * BCLK_DIV;
  localparam int FIRST_LOAD = 2 * BCLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe, underrun;
`ifdef AUDIO_VOLUME_EN
  logic [3:0] vol_shift = 4'd0;
`endif

  sd_audio_i2s_tx #(.BCLK_DIV(BCLK_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
`ifdef AUDIO_VOLUME_EN
    .vol_shift    (vol_shift),
`endif
    .byte_ready   (byte_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .sample_strobe(sample_strobe),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  logic [7:0]  src [0:511];
  int          n_acc = 0;
  int          feed_limit = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] lr_exp;
  logic        last_rdy;

  always @(posedge clk) begin
    if (rst_n && byte_valid && byte_ready) n_acc <= n_acc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    byte_valid = (n_acc < feed_limit);
    byte_data  = src[n_acc % 512];
  endtask

  task automatic step();
    @(negedge clk);
    drive();
  endtask

  task automatic wait_strobe(input string tag, input int exp_cyc);
    int cyc;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!sample_strobe && cyc < 1000);
    check(tag, cyc, exp_cyc);
  endtask

  // Starts at the negedge showing a load (k=0), ends at the negedge showing the next load.
  task automatic run_frame(input string tag, output logic [63:0] sd, output logic [63:0] lr,
                           output logic ur, output logic rdy_mid);
    int   k, cyc;
    logic prev;
    sd = '0; lr = '0; rdy_mid = 1'b0;
    ur = underrun;
    sd[0] = i2s_sdata;
    lr[0] = i2s_lrck;
    k = 0; cyc = 0; prev = i2s_bclk;
    while (cyc < 2000) begin
      step();
      cyc++;
      if (prev && !i2s_bclk) k++;
      prev = i2s_bclk;
      if (sample_strobe) break;
      if (k < 64) begin
        sd[k] = i2s_sdata;
        lr[k] = i2s_lrck;
      end
      if (k == 32) rdy_mid = byte_ready;
    end
    check({tag, "_len"}, cyc, FRAME_CYC);
    check({tag, "_falls"}, k, 64);
  endtask

  task automatic check_frame(input string tag, input logic exp_ur,
                             input logic [15:0] exp_l, input logic [15:0] exp_r);
    logic [63:0] sd, lr;
    logic        ur, rdy;
    logic [15:0] l_obs, r_obs;
    run_frame(tag, sd, lr, ur, rdy);
    for (int i = 0; i < 16; i++) begin
      l_obs[15-i] = sd[i];
      r_obs[15-i] = sd[32+i];
    end
    check({tag, "_underrun"}, ur, exp_ur);
    check({tag, "_left"}, l_obs, exp_l);
    check({tag, "_right"}, r_obs, exp_r);
    check({tag, "_pad"}, sd & 64'hFFFF_0000_FFFF_0000, 64'h0);
    check({tag, "_lrck"}, lr, lr_exp);
    last_rdy = rdy;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int falls;
    logic prev;
    for (int k = 0; k < 64; k++) lr_exp[k] = (k >= 31) && (k <= 62);
    src[0] = 8'h34; src[1] = 8'h12; src[2] = 8'h78; src[3] = 8'h56;
    for (int i = 4; i < 512; i++) src[i] = 8'(i * 7 + 3);

    // Reset state
    rst_n = 1'b0; enable = 1'b0; drive();
    #23;
    check("rst_bclk", i2s_bclk, 1'b0);
    check("rst_lrck", i2s_lrck, 1'b0);
    check("rst_sdata", i2s_sdata, 1'b0);
    check("rst_strobe", sample_strobe, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_ready", byte_ready, 1'b0);
    step(); rst_n = 1'b1;
    step(); step();
    check("idle_bclk", i2s_bclk, 1'b0);

    // Basic packing: first load underruns, the next carries 0x1234 / 0x5678
    feed_limit = 4; enable = 1'b1; drive();
    wait_strobe("t1_first_load", FIRST_LOAD);
    check_frame("t1_a", 1'b1, 16'h0, 16'h0);
    check("t1_bytes", n_acc, 4);
    check_frame("t1_b", 1'b0, 16'h1234, 16'h5678);

    // Starved FIFO: three underrun frames of silence
    for (int f = 0; f < 3; f++) check_frame("t2", 1'b1, 16'h0, 16'h0);

    // Continuous supply: four bytes per frame, back-pressure in between
    feed_limit = 1000; drive();
    check_frame("t3_f", 1'b1, 16'h0, 16'h0);
    check("t3_bytes_f", n_acc, 8);
    check("t3_ready_after_load", byte_ready, 1'b1);
    for (int j = 0; j < 3; j++) begin
      base = 4 + 4 * j;
      check_frame("t3", 1'b0, {src[base+1], src[base]}, {src[base+3], src[base+2]});
      check("t3_ready_mid", last_rdy, 1'b0);
      check("t3_bytes", n_acc, 12 + 4 * j);
    end

    // Stop with a partial sample: two bytes discarded, outputs idle, fresh start
    feed_limit = n_acc + 2; drive();
    repeat (10) step();
    check("t4_partial", n_acc, 22);
    enable = 1'b0; drive();
    for (int c = 0; c < 5; c++) begin
      step();
      check("t4_idle", {i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe, underrun, byte_ready}, 6'b0);
    end
    enable = 1'b1; feed_limit = 1000; drive();
    wait_strobe("t4_first_load", FIRST_LOAD);
    check_frame("t4_k", 1'b1, 16'h0, 16'h0);
    check_frame("t4_l", 1'b0, {src[23], src[22]}, {src[25], src[24]});

    // Asynchronous reset at k=20
    feed_limit = n_acc; drive();
    falls = 0; prev = i2s_bclk;
    while (falls < 20) begin
      step();
      if (prev && !i2s_bclk) falls++;
      prev = i2s_bclk;
    end
    #1 rst_n = 1'b0;
    #1;
    check("t5_async", {i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe, underrun}, 5'b0);
    repeat (3) step();
    check("t5_held", {i2s_bclk, i2s_lrck, i2s_sdata, sample_strobe, underrun}, 5'b0);
    rst_n = 1'b1;
    wait_strobe("t5_first_load", FIRST_LOAD);
    check_frame("t5_m", 1'b1, 16'h0, 16'h0);

`ifdef AUDIO_VOLUME_EN
    // Volume shift: 0x8000/0x4000 at shift 1, then at shift 15
    base = n_acc;
    for (int r = 0; r < 2; r++) begin
      src[base + 4*r + 0] = 8'h00; src[base + 4*r + 1] = 8'h80;
      src[base + 4*r + 2] = 8'h00; src[base + 4*r + 3] = 8'h40;
    end
    vol_shift = 4'd1; feed_limit = base + 4; drive();
    check_frame("t6_n", 1'b1, 16'h0, 16'h0);
    vol_shift = 4'd15; feed_limit = base + 8; drive();
    check_frame("t6_shift1", 1'b0, 16'hC000, 16'h2000);
    check_frame("t6_shift15", 1'b0, 16'hFFFF, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
